regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//   Parametrised multi-port register file: WIDTH x DEPTH storage, one synchronous write port and
//   two read ports. Entry 0 optionally reads as constant zero. Optional same-cycle write-to-read
//   bypass and optional registered read outputs. Next-generation storage block for the CPU
//   datapath; generalises the single/32-bit enable registers into an addressable, resettable array.
// PARAMETERS
//   WIDTH      32  bits per entry (>=1)
//   DEPTH      32  number of entries (power of two, >=2)
//   ADDR_W     5   address width, must equal log2(DEPTH)
//   ZERO_REG   1   1: entry 0 hardwired to 0, writes to it ignored; 0: entry 0 is ordinary storage
//   BYPASS     1   1: read of address being written this cycle returns writedata; 0: returns old value
//   READ_REG   0   0: combinational reads (latency 0); 1: registered read data (latency 1)
// PORTS
//   clk         in   1       clock, all state updates on rising edge
//   reset       in   1       asynchronous, active-high; clears all state
//   wrenable    in   1       write strobe, sampled on rising clk
//   writeaddr   in   ADDR_W  write address
//   writedata   in   WIDTH   write data
//   readaddr1   in   ADDR_W  read port 1 address
//   readaddr2   in   ADDR_W  read port 2 address
//   readdata1   out  WIDTH   read port 1 data
//   readdata2   out  WIDTH   read port 2 data
// BEHAVIOUR
//   - Reset (async assert, any time incl. mid-write): every entry -> 0; READ_REG output regs -> 0;
//     outputs read 0 while reset high; write in progress on the reset edge is discarded.
//   - Write: at posedge clk with reset low and wrenable=1, entry[writeaddr] <= writedata.
//     wrenable=0: no entry changes. ZERO_REG=1 and writeaddr=0: no entry changes.
//   - Read, READ_REG=0: readdataN = value(readaddrN), combinational, where value(a) is
//       0                        if ZERO_REG=1 and a=0
//       writedata                else if BYPASS=1 and wrenable=1 and a=writeaddr
//       entry[a]                 otherwise.
//   - Read, READ_REG=1: at posedge clk readdataN <= value(readaddrN) evaluated pre-edge (so with
//     BYPASS=1 a same-cycle write is visible one cycle later, identical to reading the new entry).
//     With BYPASS=0 the registered value is the pre-write contents.
//   - Both read ports independent; same address on both ports returns identical data.
//   - Read and write of same address, BYPASS=0, READ_REG=0: old value until edge, new value after.
//   - Out-of-range address impossible (DEPTH=2^ADDR_W); no X may reach outputs after reset.
//   - No internal FSM beyond storage; no handshake; write always accepted in one cycle.
// STRUCTURE
//   - Shared include regfile_defs.vh: default WIDTH/DEPTH/ADDR_W, ZERO_ADDR constant (0).
//   - Sub-module register_rst: WIDTH-bit D register with wrenable, clk, async active-high reset
//     (successor of the plain enable register); instantiated DEPTH times via generate, plus two
//     instances for READ_REG outputs (wrenable tied 1).
//   - Write decoder: one-hot ADDR_W -> DEPTH, gated by wrenable and ZERO_REG rule.
//   - Read muxes: DEPTH:1 per port, followed by bypass/zero override logic.
// TESTING
//   1. Assert reset 1 cycle, then read all 32 addrs on both ports -> every readdata = 0.
//   2. Write 32'hCC3C_39AA to addr 7, next cycle read addr 7 on both ports -> 32'hCC3C_39AA.
//   3. wrenable=0, writedata=32'hFFFF_FFFF, writeaddr=7, one edge -> addr 7 still 32'hCC3C_39AA.
//   4. ZERO_REG=1: write 32'hDEAD_BEEF to addr 0 -> readdata1 at addr 0 = 0; ZERO_REG=0 -> DEAD_BEEF.
//   5. BYPASS=1, READ_REG=0: write 32'h1234_5678 to addr 3 while readaddr2=3 -> readdata2 =
//      32'h1234_5678 before edge; BYPASS=0 -> old value before edge, new value after.
//   6. Fill addrs 1..31 with addr*32'h0101_0101, assert reset mid-cycle (not on edge) -> outputs 0
//      immediately; READ_REG=1 case: readdata updates exactly one edge after readaddr changes.

Source files
------------

// File: rtl/regfile_param_pkg.sv
// Shared defaults and constants for the parametrised register file.
package regfile_param_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;

    // Entry that reads as constant zero when ZERO_REG is enabled.
    localparam int ZERO_ADDR  = 0;

    // Legal geometry: DEPTH is a power of two at least 2, addressed by exactly ADDR_W bits.
    function automatic bit geometry_ok(input int depth, input int addr_w);
        return (depth >= 2) && (depth == (1 << addr_w));
    endfunction

endpackage

// File: rtl/regfile_param_register_rst.sv
// WIDTH-bit D register with load enable and asynchronous active-high clear.
module register_rst #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrenable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, clear immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (wrenable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Register file: DEPTH x WIDTH storage, one write port, two read ports,
// optional hardwired-zero entry 0, optional write-to-read bypass, optional output registers.
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrenable,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [WIDTH-1:0]  writedata,
    input  logic [ADDR_W-1:0] readaddr1,
    input  logic [ADDR_W-1:0] readaddr2,
    output logic [WIDTH-1:0]  readdata1,
    output logic [WIDTH-1:0]  readdata2
);

    localparam logic [ADDR_W-1:0] ZADDR   = ADDR_W'(ZERO_ADDR);
    localparam bit                GEOM_OK = geometry_ok(DEPTH, ADDR_W);

    logic [DEPTH-1:0] w_wr_onehot;
    logic [WIDTH-1:0] w_entry [DEPTH];
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic             w_zero_wr;

    assign w_zero_wr = (ZERO_REG != 0) && (writeaddr == ZADDR);

    // One-hot write select; writes to the hardwired-zero entry are dropped here.
    always_comb begin
        w_wr_onehot = '0;
        if (GEOM_OK && wrenable && !w_zero_wr) begin
            w_wr_onehot[writeaddr] = 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        register_rst #(.WIDTH(WIDTH)) u_entry (
            .clk      (clk),
            .reset    (reset),
            .wrenable (w_wr_onehot[g]),
            .d        (writedata),
            .q        (w_entry[g])
        );
    end

    // Port 1 value: array mux, then bypass, then zero-entry and reset overrides.
    always_comb begin
        w_rd1 = w_entry[readaddr1];
        if ((BYPASS != 0) && wrenable && (readaddr1 == writeaddr)) begin
            w_rd1 = writedata;
        end
        if ((ZERO_REG != 0) && (readaddr1 == ZADDR)) begin
            w_rd1 = '0;
        end
        if (reset) begin
            w_rd1 = '0;
        end
    end

    // Port 2 value: same selection as port 1.
    always_comb begin
        w_rd2 = w_entry[readaddr2];
        if ((BYPASS != 0) && wrenable && (readaddr2 == writeaddr)) begin
            w_rd2 = writedata;
        end
        if ((ZERO_REG != 0) && (readaddr2 == ZADDR)) begin
            w_rd2 = '0;
        end
        if (reset) begin
            w_rd2 = '0;
        end
    end

    if (READ_REG != 0) begin : g_read_reg
        register_rst #(.WIDTH(WIDTH)) u_rd1 (
            .clk      (clk),
            .reset    (reset),
            .wrenable (1'b1),
            .d        (w_rd1),
            .q        (readdata1)
        );
        register_rst #(.WIDTH(WIDTH)) u_rd2 (
            .clk      (clk),
            .reset    (reset),
            .wrenable (1'b1),
            .d        (w_rd2),
            .q        (readdata2)
        );
    end else begin : g_read_comb
        assign readdata1 = w_rd1;
        assign readdata2 = w_rd2;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven in parallel from shared inputs.
//   dut_a: ZERO_REG=1 BYPASS=1 READ_REG=0
//   dut_b: ZERO_REG=0 BYPASS=0 READ_REG=0
//   dut_c: ZERO_REG=1 BYPASS=1 READ_REG=1
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        wrenable;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic [4:0]  readaddr1;
    logic [4:0]  readaddr2;
    logic [31:0] rd_a1, rd_a2, rd_b1, rd_b2, rd_c1, rd_c2;

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) dut_a (
        .clk(clk), .reset(reset), .wrenable(wrenable), .writeaddr(writeaddr), .writedata(writedata),
        .readaddr1(readaddr1), .readaddr2(readaddr2), .readdata1(rd_a1), .readdata2(rd_a2));

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0), .READ_REG(0)) dut_b (
        .clk(clk), .reset(reset), .wrenable(wrenable), .writeaddr(writeaddr), .writedata(writedata),
        .readaddr1(readaddr1), .readaddr2(readaddr2), .readdata1(rd_b1), .readdata2(rd_b2));

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .READ_REG(1)) dut_c (
        .clk(clk), .reset(reset), .wrenable(wrenable), .writeaddr(writeaddr), .writedata(writedata),
        .readaddr1(readaddr1), .readaddr2(readaddr2), .readdata1(rd_c1), .readdata2(rd_c2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference storage: mem_z for the zero-entry configs (a, c), mem_b for config b.
    logic [31:0] mem_z [32];
    logic [31:0] mem_b [32];

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] ea1;
        logic [31:0] ea2;
        logic [31:0] eb1;
        logic [31:0] eb2;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] val_z(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wrenable && a == writeaddr) return writedata;
        return mem_z[a];
    endfunction

    function automatic logic [31:0] val_b(input logic [4:0] a);
        return mem_b[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            mem_z[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
    endtask

    // One cycle: drive at negedge, check combinational configs before the edge,
    // queue the registered-config expectation, update the model on the edge,
    // then pop and check the registered config at the next negedge.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2);
        exp_t e;
        wrenable  = we;
        writeaddr = wa;
        writedata = wd;
        readaddr1 = ra1;
        readaddr2 = ra2;
        #2;
        chk("a_rd1", rd_a1, val_z(ra1));
        chk("a_rd2", rd_a2, val_z(ra2));
        chk("b_rd1", rd_b1, val_b(ra1));
        chk("b_rd2", rd_b2, val_b(ra2));
        e.e1 = val_z(ra1);
        e.e2 = val_z(ra2);
        sb_q.push_back(e);
        @(posedge clk);
        if (we) begin
            if (wa != 5'd0) mem_z[wa] = wd;
            mem_b[wa] = wd;
        end
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("c_queue_empty", 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            chk("c_rd1", rd_c1, e.e1);
            chk("c_rd2", rd_c2, e.e2);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd7,  32'hCC3C_39AA, 5'd7,  5'd7, 32'hCC3C_39AA, 32'hCC3C_39AA, 32'h0,         32'h0};
        vecs[1] = '{1'b0, 5'd7,  32'hFFFF_FFFF, 5'd7,  5'd7, 32'hCC3C_39AA, 32'hCC3C_39AA, 32'hCC3C_39AA, 32'hCC3C_39AA};
        vecs[2] = '{1'b0, 5'd7,  32'hFFFF_FFFF, 5'd7,  5'd7, 32'hCC3C_39AA, 32'hCC3C_39AA, 32'hCC3C_39AA, 32'hCC3C_39AA};
        vecs[3] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd7, 32'h0,         32'hCC3C_39AA, 32'h0,         32'hCC3C_39AA};
        vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0, 32'h0,         32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 5'd3,  32'h1234_5678, 5'd7,  5'd3, 32'hCC3C_39AA, 32'h1234_5678, 32'hCC3C_39AA, 32'h0};
        vecs[6] = '{1'b0, 5'd3,  32'h0,         5'd3,  5'd3, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        vecs[7] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd30, 32'hA5A5_A5A5, 32'h0,        32'h0,         32'h0};
        vecs[8] = '{1'b0, 5'd31, 32'h0,         5'd31, 5'd0, 32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5, 32'hDEAD_BEEF};

        clear_model();

        // Reset with a write and a bypass-matching read active: outputs stay 0, write is discarded.
        reset     = 1'b1;
        wrenable  = 1'b1;
        writeaddr = 5'd5;
        writedata = 32'hFFFF_FFFF;
        readaddr1 = 5'd5;
        readaddr2 = 5'd5;
        #3;
        chk("rst_a_rd1", rd_a1, 32'h0);
        chk("rst_b_rd2", rd_b2, 32'h0);
        chk("rst_c_rd1", rd_c1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_a_bypass_blocked", rd_a1, 32'h0);
        reset    = 1'b0;
        wrenable = 1'b0;

        // All entries read zero on both ports after reset.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        end

        // Directed vectors with fixed expectations for the two combinational configs.
        for (int i = 0; i < 9; i++) begin
            wrenable  = vecs[i].we;
            writeaddr = vecs[i].wa;
            writedata = vecs[i].wd;
            readaddr1 = vecs[i].ra1;
            readaddr2 = vecs[i].ra2;
            #1;
            chk($sformatf("vec%0d_a1", i), rd_a1, vecs[i].ea1);
            chk($sformatf("vec%0d_a2", i), rd_a2, vecs[i].ea2);
            chk($sformatf("vec%0d_b1", i), rd_b1, vecs[i].eb1);
            chk($sformatf("vec%0d_b2", i), rd_b2, vecs[i].eb2);
            step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
        end

        // Fill entries 1..31, then assert reset between clock edges.
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 5'(i), i * 32'h0101_0101, 5'(i), 5'(i - 1));
        end
        wrenable  = 1'b0;
        readaddr1 = 5'd5;
        readaddr2 = 5'd9;
        #1;
        chk("pre_rst_a_rd1", rd_a1, 32'h0505_0505);
        chk("pre_rst_b_rd2", rd_b2, 32'h0909_0909);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_a_rd1", rd_a1, 32'h0);
        chk("midrst_a_rd2", rd_a2, 32'h0);
        chk("midrst_b_rd1", rd_b1, 32'h0);
        chk("midrst_b_rd2", rd_b2, 32'h0);
        chk("midrst_c_rd1", rd_c1, 32'h0);
        chk("midrst_c_rd2", rd_c2, 32'h0);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst_b_rd1", rd_b1, 32'h0);

        // Registered-read latency: data follows a read address change by exactly one edge.
        step(1'b1, 5'd9, 32'h0909_0909, 5'd2, 5'd2);
        wrenable  = 1'b0;
        readaddr1 = 5'd9;
        readaddr2 = 5'd9;
        #2;
        chk("lat_a_rd1_now", rd_a1, 32'h0909_0909);
        chk("lat_c_rd1_before_edge", rd_c1, 32'h0);
        chk("lat_c_rd2_before_edge", rd_c2, 32'h0);
        @(posedge clk);
        #1;
        chk("lat_c_rd1_after_edge", rd_c1, 32'h0909_0909);
        chk("lat_c_rd2_after_edge", rd_c2, 32'h0909_0909);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
